// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: accepts a word on valid/ready and emits it one bit per clock; first bit 1 cycle after accept, en=0 freezes.
// Build with SER_PARITY_EN defined to append an even-parity bit after the data bits.
module bit_serializer #(
  parameter int W         = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic         ck,
  input  logic         r,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         en,
  output logic         so,
  output logic         so_valid,
  output logic         last,
  output logic         busy
);

`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
  // The IDLE cycle that precedes the next accept is itself one of the GAP bubbles.
  localparam logic [3:0] GAP_LAST = (GAP > 1) ? 4'(GAP - 2) : 4'd0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]    state;
  logic [NB-1:0] sr;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic [NB-1:0] load_word;
  logic          head;
  logic          at_last;

`ifdef SER_PARITY_EN
  logic par;
  assign par       = ^din;
  assign load_word = (MSB_FIRST != 0) ? {din, par} : {par, din};
`else
  assign load_word = din;
`endif

  assign head      = (MSB_FIRST != 0) ? sr[NB-1] : sr[0];
  assign at_last   = (bit_cnt == LAST_IDX);
  assign so_valid  = (state == ST_SHIFT);
  assign so        = so_valid & head;
  assign last      = so_valid & at_last;
  assign busy      = (state != ST_IDLE);
  assign din_ready = (state == ST_IDLE) ||
                     ((GAP == 0) && (state == ST_SHIFT) && en && at_last);

  always_ff @(posedge ck) begin
    if (r) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (din_valid) begin
            sr      <= load_word;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (en) begin
            if (at_last) begin
              bit_cnt <= '0;
              if (din_valid && din_ready) begin
                sr <= load_word;
              end else if (GAP > 1) begin
                sr      <= '0;
                gap_cnt <= '0;
                state   <= ST_GAP;
              end else begin
                sr    <= '0;
                state <= ST_IDLE;
              end
            end else begin
              sr      <= (MSB_FIRST != 0) ? {sr[NB-2:0], 1'b0} : {1'b0, sr[NB-1:1]};
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        ST_GAP: begin
          if (en) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances (MSB/GAP=0, MSB/GAP=3, LSB/GAP=0) with a per-instance bit scoreboard.
module tb_bit_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic [2:0] r  = 3'b111;
  logic [2:0] dv = 3'b000;
  logic [2:0] en = 3'b111;
  logic [7:0] din [3];
  wire  [2:0] rdy, so, sv, lst, bsy;

  int errors = 0;
  int checks = 0;
  logic [1:0] q0 [$];
  logic [1:0] q1 [$];
  logic [1:0] q2 [$];

  bit_serializer #(.W(8), .MSB_FIRST(1), .GAP(0)) u0 (
    .ck(ck), .r(r[0]), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]), .en(en[0]),
    .so(so[0]), .so_valid(sv[0]), .last(lst[0]), .busy(bsy[0]));
  bit_serializer #(.W(8), .MSB_FIRST(1), .GAP(3)) u1 (
    .ck(ck), .r(r[1]), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]), .en(en[1]),
    .so(so[1]), .so_valid(sv[1]), .last(lst[1]), .busy(bsy[1]));
  bit_serializer #(.W(8), .MSB_FIRST(0), .GAP(0)) u2 (
    .ck(ck), .r(r[2]), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]), .en(en[2]),
    .so(so[2]), .so_valid(sv[2]), .last(lst[2]), .busy(bsy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {so,last} per bit, in wire order, for instance k.
  task automatic push_word(input int k, input logic [7:0] w);
    logic [1:0] e;
    for (int i = 0; i < NB; i++) begin
      if (i < W) e[1] = (k == 2) ? w[i] : w[W-1-i];
      else       e[1] = ^w;
      e[0] = (i == NB - 1);
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic mon(input int k);
    logic [1:0] e;
    int n;
    if (r[k] || !sv[k]) return;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      check($sformatf("unexpected_bit_u%0d", k), {31'b0, sv[k]}, 0);
      return;
    end
    e = (k == 0) ? q0[0] : (k == 1) ? q1[0] : q2[0];
    check($sformatf("so_u%0d", k), {31'b0, so[k]}, {31'b0, e[1]});
    check($sformatf("last_u%0d", k), {31'b0, lst[k]}, {31'b0, e[0]});
    if (en[k]) begin
      case (k)
        0:       void'(q0.pop_front());
        1:       void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
    end
  endtask

  always @(negedge ck) begin
    mon(0);
    mon(1);
    mon(2);
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_so_valid_u%0d", k), {31'b0, sv[k]}, 0);
      check($sformatf("rst_so_u%0d", k), {31'b0, so[k]}, 0);
      check($sformatf("rst_last_u%0d", k), {31'b0, lst[k]}, 0);
      check($sformatf("rst_busy_u%0d", k), {31'b0, bsy[k]}, 0);
      check($sformatf("rst_ready_u%0d", k), {31'b0, rdy[k]}, 1);
    end
    r = 3'b000;

    // Single word, MSB first, latency 1.
    din[0] = 8'hA5; dv[0] = 1'b1; push_word(0, 8'hA5);
    tick();
    dv[0] = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      check("t1_valid", {31'b0, sv[0]}, 1);
      check("t1_last", {31'b0, lst[0]}, {31'b0, (c == NB)});
      tick();
    end
    check("t1_idle_valid", {31'b0, sv[0]}, 0);
    check("t1_ready_after", {31'b0, rdy[0]}, 1);

    // Back-to-back, no bubble.
    din[0] = 8'hA5; dv[0] = 1'b1; push_word(0, 8'hA5);
    tick();
    din[0] = 8'h5A; push_word(0, 8'h5A);
    for (int c = 1; c <= 2 * NB; c++) begin
      check("t2_valid", {31'b0, sv[0]}, 1);
      check("t2_last", {31'b0, lst[0]}, {31'b0, (c == NB || c == 2 * NB)});
      if (c == 3)  check("t2_ready_mid", {31'b0, rdy[0]}, 0);
      if (c == NB) check("t2_ready_last", {31'b0, rdy[0]}, 1);
      tick();
      if (c == NB) dv[0] = 1'b0;
    end
    check("t2_end_valid", {31'b0, sv[0]}, 0);

    // GAP=3: three so_valid=0 cycles between words.
    din[1] = 8'hA5; dv[1] = 1'b1; push_word(1, 8'hA5);
    tick();
    din[1] = 8'h5A; push_word(1, 8'h5A);
    for (int c = 1; c <= 2 * NB + 4; c++) begin
      check("t3_valid", {31'b0, sv[1]},
            {31'b0, ((c <= NB) || (c > NB + 3 && c <= 2 * NB + 3))});
      if (c > NB && c <= NB + 2) begin
        check("t3_gap_ready", {31'b0, rdy[1]}, 0);
        check("t3_gap_busy", {31'b0, bsy[1]}, 1);
      end
      if (c == NB + 3) check("t3_accept_ready", {31'b0, rdy[1]}, 1);
      tick();
      if (c == NB + 3) dv[1] = 1'b0;
    end

    // en=0 for two cycles while bit 3 (a zero) is on so.
    din[0] = 8'hA5; dv[0] = 1'b1; push_word(0, 8'hA5);
    tick();
    dv[0] = 1'b0;
    for (int c = 1; c <= NB + 2; c++) begin
      en[0] = !(c == 5 || c == 6);
      check("t4_valid", {31'b0, sv[0]}, 1);
      check("t4_last", {31'b0, lst[0]}, {31'b0, (c == NB + 2)});
      if (c >= 5 && c <= 7) check("t4_hold_so", {31'b0, so[0]}, 0);
      tick();
    end
    en[0] = 1'b1;
    check("t4_end_valid", {31'b0, sv[0]}, 0);

    // Reset mid-word, then an LSB-first word.
    din[2] = 8'hFF; dv[2] = 1'b1; push_word(2, 8'hFF);
    tick();
    dv[2] = 1'b0;
    tick();
    tick();
    tick();
    r[2] = 1'b1;
    q2.delete();
    tick();
    check("t5_valid", {31'b0, sv[2]}, 0);
    check("t5_so", {31'b0, so[2]}, 0);
    check("t5_busy", {31'b0, bsy[2]}, 0);
    check("t5_ready", {31'b0, rdy[2]}, 1);
    check("t5_last", {31'b0, lst[2]}, 0);
    r[2] = 1'b0;
    din[2] = 8'h01; dv[2] = 1'b1; push_word(2, 8'h01);
    tick();
    dv[2] = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      check("t5b_valid", {31'b0, sv[2]}, 1);
      check("t5b_last", {31'b0, lst[2]}, {31'b0, (c == NB)});
      tick();
    end
    check("t5b_end_valid", {31'b0, sv[2]}, 0);

    // 8'h07: with parity the ninth bit is 1.
    din[0] = 8'h07; dv[0] = 1'b1; push_word(0, 8'h07);
    tick();
    dv[0] = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      check("t6_valid", {31'b0, sv[0]}, 1);
      check("t6_last", {31'b0, lst[0]}, {31'b0, (c == NB)});
      tick();
    end
    check("t6_end_valid", {31'b0, sv[0]}, 0);

    tick();
    check("drain_u0", q0.size(), 0);
    check("drain_u1", q1.size(), 0);
    check("drain_u2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
